// File: rtl/mem_pkg.sv
// mem_pkg: default sizes and pointer/count width helpers shared by the history buffer files
package mem_pkg;
    localparam int DEF_WIDTH = 35;
    localparam int DEF_DEPTH = 8;
    localparam int PTR_W = $clog2(DEF_DEPTH);
    localparam int CNT_W = $clog2(DEF_DEPTH + 1);
    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/mem_history_buffer_if.sv
// mem_history_buffer_if: writer/reader bus of the history buffer.
//   master drives wren/din/rden/clr_ovf; slave (the buffer) drives dout/dout_valid/last/count/full/empty/ovf
interface mem_history_buffer_if
    import mem_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
);
    logic                     wren;
    logic [WIDTH-1:0]         din;
    logic                     rden;
    logic                     clr_ovf;
    logic [WIDTH-1:0]         dout;
    logic                     dout_valid;
    logic [WIDTH-1:0]         last;
    logic [cnt_w(DEPTH)-1:0]  count;
    logic                     full;
    logic                     empty;
    logic                     ovf;
    modport master (
        output wren, din, rden, clr_ovf,
        input  dout, dout_valid, last, count, full, empty, ovf
    );
    modport slave (
        input  wren, din, rden, clr_ovf,
        output dout, dout_valid, last, count, full, empty, ovf
    );
endinterface

// File: rtl/mem_history_ram.sv
// mem_history_ram: DEPTH x WIDTH register array with one synchronous write port and one registered read port.
//   clk/rst_n: clock and sync active-low reset (read register only; contents are not reset)
//   we/waddr/wdata: write port; re/raddr/rdata: registered read port
module mem_history_ram
    import mem_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    we,
    input  logic [ptr_w(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]        wdata,
    input  logic                    re,
    input  logic [ptr_w(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]        rdata
);
    logic [WIDTH-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end
    // a read and a write to the same slot return the old word, which is what a full-buffer pop+write needs
    always_ff @(posedge clk) begin
        if (!rst_n) rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/mem_history_buffer.sv
// mem_history_buffer: DEPTH-entry circular history of WIDTH-bit words with registered pop read-out.
//   clk/rst_n: clock and sync active-low reset
//   bus (slave): wren/din write, rden pop, clr_ovf clears sticky ovf; dout/dout_valid popped word,
//   last = most recent accepted write, count/full/empty occupancy, ovf sticky overflow
//   OVERWRITE=1 drops the oldest entry when full, OVERWRITE=0 drops the incoming word
module mem_history_buffer
    import mem_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter bit OVERWRITE = 1'b1
) (
    input logic clk,
    input logic rst_n,
    mem_history_buffer_if.slave bus
);
    localparam int AW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] last;
    logic             dout_valid, ovf, pop, wr_ok, ovf_evt;
    assign bus.full       = count == CW'(DEPTH);
    assign bus.empty      = count == '0;
    assign bus.count      = count;
    assign bus.last       = last;
    assign bus.dout_valid = dout_valid;
    assign bus.ovf        = ovf;
    assign pop     = bus.rden && !bus.empty;
    assign wr_ok   = bus.wren && (!bus.full || pop || OVERWRITE);
    // a write hitting a full buffer without a same-edge pop, whether it overwrites or is dropped
    assign ovf_evt = bus.wren && bus.full && !pop;
    mem_history_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (rst_n && wr_ok),
        .waddr (wr_ptr),
        .wdata (bus.din),
        .re    (pop),
        .raddr (rd_ptr),
        .rdata (bus.dout)
    );
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            last       <= '0;
            dout_valid <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
                last   <= bus.din;
            end
            // overwriting a full buffer retires the oldest entry by moving the read side along
            if (pop || (wr_ok && ovf_evt)) rd_ptr <= rd_ptr + 1'b1;
            count      <= (wr_ok && !pop && !bus.full) ? count + 1'b1 :
                          (pop && !wr_ok)              ? count - 1'b1 : count;
            dout_valid <= pop;
            ovf        <= ovf_evt || (ovf && !bus.clr_ovf);
        end
    end
endmodule
